// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one external up-counter between two requesters, one run at a time.
// Define COUNTER_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module counter_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_0,
    input  logic             req_1,
    input  logic [WIDTH-1:0] len_0,
    input  logic [WIDTH-1:0] len_1,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             any_req;
    logic             winner;
    logic             at_target;

    assign any_req   = req_0 || req_1;
    assign at_target = (cnt_value == target_q);

`ifdef COUNTER_ARB_RR_EN
    // last_q holds the requester served most recently; the other one wins a tie.
    logic last_q, last_d;

    assign winner = (req_0 && req_1) ? ~last_q : req_1;

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = req_1 && !req_0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StClear;
                    owner_d = winner;
                end
            end
            StClear: begin
                state_d  = StRun;
                target_d = owner_q ? len_1 : len_0;
            end
            StRun: begin
                if (at_target) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            target_q <= target_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign cnt_reset  = (state_q == StClear);
    assign cnt_enable = (state_q == StRun) && !at_target;
    assign gnt        = busy ? {owner_q, ~owner_q} : 2'b00;
    assign done       = (state_q == StDone) ? {owner_q, ~owner_q} : 2'b00;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: timeline reference model feeds a scoreboard checked by a monitor.
// Honours COUNTER_ARB_RR_EN the same way as the design when predicting tie winners.
module tb_counter_arbiter;

    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_0, req_1;
    logic [W-1:0] len_0, len_1, cnt_value;
    logic         cnt_reset, cnt_enable, busy;
    logic [1:0]   gnt, done;

    counter_arbiter #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_0      (req_0),
        .req_1      (req_1),
        .len_0      (len_0),
        .len_1      (len_1),
        .cnt_value  (cnt_value),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Plain wrapping counter standing in for the shared counter instance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_value <= '0;
        else if (cnt_reset) cnt_value <= '0;
        else if (cnt_enable) cnt_value <= cnt_value + 1'b1;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int owner;
        int len;
        int start;
        int done_cyc;
    } run_t;

    run_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   active[2];
    int   mlen[2];
    int   drop_at[2];
    int   rest_until[2];
    int   idle_at;
    int   en_count;
    bit   mon_en;
`ifdef COUNTER_ARB_RR_EN
    int   last_served;
`endif

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            active[i]     = 1'b0;
            drop_at[i]    = -1;
            rest_until[i] = 0;
        end
        idle_at  = cyc;
        en_count = 0;
`ifdef COUNTER_ARB_RR_EN
        last_served = 1;
`endif
    endtask

    // One call per cycle at the falling edge: drives requests and predicts each granted run.
    task automatic drive_cycle(input bit w0, input bit w1, input int l0, input int l1);
        bit want[2];
        int lreq[2];
        int w;
        want[0] = w0;
        want[1] = w1;
        lreq[0] = l0;
        lreq[1] = l1;
        for (int i = 0; i < 2; i++) begin
            if (active[i] && drop_at[i] == cyc) begin
                active[i]     = 1'b0;
                rest_until[i] = cyc + 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!active[i] && want[i] && cyc >= rest_until[i]) begin
                active[i]  = 1'b1;
                mlen[i]    = lreq[i];
                drop_at[i] = -1;
            end
        end
        req_0 = active[0];
        req_1 = active[1];
        len_0 = active[0] ? W'(mlen[0]) : W'($urandom);
        len_1 = active[1] ? W'(mlen[1]) : W'($urandom);
        if (cyc >= idle_at && (active[0] || active[1])) begin
            if (active[0] && active[1]) begin
`ifdef COUNTER_ARB_RR_EN
                w = 1 - last_served;
`else
                w = 0;
`endif
            end else begin
                w = active[1] ? 1 : 0;
            end
            exp_q.push_back('{w, mlen[w], cyc + 1, cyc + mlen[w] + 3});
            drop_at[w] = cyc + mlen[w] + 4;
            idle_at    = cyc + mlen[w] + 4;
`ifdef COUNTER_ARB_RR_EN
            last_served = w;
`endif
        end
    endtask

    task automatic settle();
        int guard = 0;
        while ((active[0] || active[1] || exp_q.size() != 0 || cyc < idle_at) && guard < 100) begin
            @(negedge clock);
            drive_cycle(1'b0, 1'b0, 0, 0);
            guard++;
        end
        if (active[0] || active[1] || exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL settle_timeout: got %0d runs outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic monitor_cycle();
        run_t r;
        int eg, eb, er, ee, ed, ev;
        if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            r = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done by cycle %0d, expected done=%0d at cycle %0d",
                     cyc, 1 << r.owner, r.done_cyc);
            en_count = 0;
        end
        eg = 0; eb = 0; er = 0; ee = 0; ed = 0; ev = -1;
        if (exp_q.size() > 0) begin
            r = exp_q[0];
            if (cyc >= r.start && cyc <= r.done_cyc) begin
                eg = 1 << r.owner;
                eb = 1;
                er = (cyc == r.start) ? 1 : 0;
                ee = (cyc > r.start && cyc <= r.start + r.len) ? 1 : 0;
                ed = (cyc == r.done_cyc) ? eg : 0;
                if (cyc > r.start) ev = (cyc - r.start - 1 < r.len) ? cyc - r.start - 1 : r.len;
            end
        end
        if (cnt_enable) en_count++;
        check("gnt", int'(gnt), eg);
        check("busy", int'(busy), eb);
        check("cnt_reset", int'(cnt_reset), er);
        check("cnt_enable", int'(cnt_enable), ee);
        check("done", int'(done), ed);
        if (ev >= 0) check("cnt_value", int'(cnt_value), ev);
        if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done=%0d, expected 0", done);
            end else begin
                r = exp_q.pop_front();
                check("done_owner", int'(done), 1 << r.owner);
                check("done_cycle", cyc, r.done_cyc);
                check("enable_cycles", en_count, r.len);
                en_count = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) monitor_cycle();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mon_en = 1'b0;
        reset  = 1'b1;
        req_0  = 1'b1;
        req_1  = 1'b1;
        len_0  = 4'd3;
        len_1  = 4'd3;
        repeat (3) @(negedge clock);
        check("reset_gnt", int'(gnt), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cnt_reset", int'(cnt_reset), 0);
        check("reset_cnt_enable", int'(cnt_enable), 0);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive_cycle(1'b0, 1'b0, 0, 0);

        // Single run, zero length, maximum length.
        @(negedge clock); drive_cycle(1'b1, 1'b0, 5, 0);  settle();
        @(negedge clock); drive_cycle(1'b0, 1'b1, 0, 0);  settle();
        @(negedge clock); drive_cycle(1'b1, 1'b0, 15, 0); settle();

        // Both held high and re-raised as soon as allowed.
        repeat (24) begin
            @(negedge clock);
            drive_cycle(1'b1, 1'b1, 2, 2);
        end
        settle();

        // Requester 0 served alone, then a simultaneous tie: the policy picks the winner.
        @(negedge clock); drive_cycle(1'b1, 1'b0, 1, 0); settle();
        @(negedge clock); drive_cycle(1'b1, 1'b1, 3, 4); settle();

        // Reset in the 4th RUN cycle of a length-10 run.
        @(negedge clock); drive_cycle(1'b1, 1'b0, 10, 0);
        repeat (4) begin
            @(negedge clock);
            drive_cycle(1'b0, 1'b0, 0, 0);
        end
        @(negedge clock);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("midrun_gnt", int'(gnt), 0);
        check("midrun_done", int'(done), 0);
        check("midrun_busy", int'(busy), 0);
        check("midrun_cnt_reset", int'(cnt_reset), 0);
        check("midrun_cnt_enable", int'(cnt_enable), 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive_cycle(1'b1, 1'b1, 3, 7);
        settle();

        // Randomized traffic.
        repeat (800) begin
            @(negedge clock);
            drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15), $urandom_range(0, 15));
        end
        settle();
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
